// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin two-master arbiter and access sequencer for a single-port SRAM.
// Defining SRAM_ARB_LOCK_EN adds m0_lock/m1_lock for exclusive ownership across several accesses.
module sram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
`ifdef SRAM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_csb_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        req_eff;
    logic              gnt_any, gnt_sel;
`ifdef SRAM_ARB_LOCK_EN
    logic              lock_q, lock_d;
    logic              lock_owner_q, lock_owner_d;
`endif

    // Hide the non-owner's request while a lock is held, then pick the winner (tie goes away from last_q)
    always_comb begin
        req_eff = {m1_req, m0_req};
`ifdef SRAM_ARB_LOCK_EN
        if (lock_q) req_eff = lock_owner_q ? {m1_req, 1'b0} : {1'b0, m0_req};
`endif
        gnt_sel = (req_eff == 2'b11) ? ~last_q : req_eff[1];
        gnt_any = (state_q == IDLE) && (req_eff != 2'b00) && !rst;
    end

    // Sequencer: latch command on grant, one ACCESS cycle, then count down the read latency
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        rvalid_d  = 2'b00;
`ifdef SRAM_ARB_LOCK_EN
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = ACCESS;
                    owner_d = gnt_sel;
                    we_d    = gnt_sel ? m1_we    : m0_we;
                    addr_d  = gnt_sel ? m1_addr  : m0_addr;
                    wdata_d = gnt_sel ? m1_wdata : m0_wdata;
`ifdef SRAM_ARB_LOCK_EN
                    if (!lock_q) last_d = gnt_sel;
                    lock_d       = gnt_sel ? m1_lock : m0_lock;
                    lock_owner_d = gnt_sel;
`else
                    last_d = gnt_sel;
`endif
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RDWAIT;
                cnt_d   = LAT_M1;
            end
            RDWAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d   = IDLE;
                    rd_data_d = sram_dout;
                    rvalid_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; reset drops any in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 2'd0;
            rd_data_q <= '0;
            rvalid_q  <= 2'b00;
`ifdef SRAM_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rvalid_q  <= rvalid_d;
`ifdef SRAM_ARB_LOCK_EN
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
`endif
        end
    end

    // SRAM pins decode straight from state_q so an async reset deselects at once
    assign sram_csb_n = (state_q != ACCESS);
    assign sram_we_n  = (state_q == ACCESS) ? !we_q : 1'b1;
    assign sram_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign sram_din   = (state_q == ACCESS && we_q) ? wdata_q : '0;

    assign m0_gnt    = gnt_any && !gnt_sel;
    assign m1_gnt    = gnt_any && gnt_sel;
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench driving three arbiters (RD_LAT 1,2,3) each with its own SRAM model.
module tb_sram_port_arbiter;
    typedef struct { int k; int m; } gnt_e;
    typedef struct { int k; logic we_n; logic [4:0] a; logic [31:0] d; } acc_e;
    typedef struct { int k; int m; logic [31:0] d; } rv_e;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req [3];
    logic [1:0]  we [3];
    logic [4:0]  addr [3][2];
    logic [31:0] wdata [3][2];
`ifdef SRAM_ARB_LOCK_EN
    logic [1:0]  lock [3];
`endif
    logic        gnt0 [3], gnt1 [3], rv0 [3], rv1 [3], csb_n [3], we_n [3];
    logic [31:0] rd_data [3], s_din [3];
    logic [4:0]  s_addr [3];

    gnt_e gq[$];
    acc_e aq[$];
    rv_e  rq[$];
    gnt_e ge;
    acc_e ae;
    rv_e  re;
    int   checks = 0, passes = 0, cyc = 0;
    int   gcyc [3][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_lat
        logic [31:0] mem [32];
        logic [31:0] pipe [g+1];
        sram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(g+1)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
            .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
`ifdef SRAM_ARB_LOCK_EN
            .m0_lock(lock[g][0]), .m1_lock(lock[g][1]),
`endif
            .m0_gnt(gnt0[g]), .m1_gnt(gnt1[g]), .m0_rvalid(rv0[g]), .m1_rvalid(rv1[g]),
            .rd_data(rd_data[g]), .sram_csb_n(csb_n[g]), .sram_we_n(we_n[g]),
            .sram_addr(s_addr[g]), .sram_din(s_din[g]), .sram_dout(pipe[g])
        );
        // Synchronous SRAM with g+1 output stages; junk on non-read cycles exposes mistimed sampling
        always @(posedge clk) begin
            if (!csb_n[g] && !we_n[g]) mem[s_addr[g]] <= s_din[g];
            pipe[0] <= (!csb_n[g] && we_n[g]) ? mem[s_addr[g]] : 32'hBAD0_0000 + 32'(g);
            for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic timeout(input string n);
        checks++;
        $display("FAIL %s: no response within cycle budget", n);
    endtask

    // Monitor: every DUT output event pops and checks the matching expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (gnt0[k] || gnt1[k]) begin
                    if (gq.size() == 0) chk("unexpected_gnt", {gnt1[k], gnt0[k]}, 2'b00);
                    else begin
                        ge = gq.pop_front();
                        chk("gnt_inst", 64'(k), 64'(ge.k));
                        chk("gnt_vec", {gnt1[k], gnt0[k]}, ge.m ? 2'b10 : 2'b01);
                    end
                    if (gnt0[k]) gcyc[k][0] = cyc;
                    if (gnt1[k]) gcyc[k][1] = cyc;
                end
                if (!csb_n[k]) begin
                    if (aq.size() == 0) chk("unexpected_access", {31'd0, csb_n[k]}, 32'd1);
                    else begin
                        ae = aq.pop_front();
                        chk("acc_inst", 64'(k), 64'(ae.k));
                        chk("acc_pins", {we_n[k], s_addr[k], s_din[k]}, {ae.we_n, ae.a, ae.d});
                    end
                end else chk("idle_pins", {we_n[k], s_addr[k], s_din[k]}, {1'b1, 5'd0, 32'd0});
                if (rv0[k] || rv1[k]) begin
                    if (rq.size() == 0) chk("unexpected_rvalid", {rv1[k], rv0[k]}, 2'b00);
                    else begin
                        re = rq.pop_front();
                        chk("rv_inst", 64'(k), 64'(re.k));
                        chk("rv_vec", {rv1[k], rv0[k]}, re.m ? 2'b10 : 2'b01);
                        chk("rd_data", rd_data[k], re.d);
                        chk("rd_latency", 64'(cyc - gcyc[k][re.m]), 64'(k + 3));
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input int k, input int m);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(m ? gnt1[k] : gnt0[k]) && n < 60);
        if (n >= 60) timeout("gnt_wait");
        @(posedge clk); #1;
    endtask

    task automatic issue(input int k, input int m, input bit w, input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req[k][m] = 1'b1; we[k][m] = w; addr[k][m] = a; wdata[k][m] = d;
        gq.push_back('{k, m});
        aq.push_back('{k, !w, a, w ? d : 32'd0});
        if (!w) rq.push_back('{k, m, d});
        wait_gnt(k, m);
        req[k][m] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((gq.size() + aq.size() + rq.size()) != 0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("drain");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 2'b11; we[k] = 2'b00;
            for (int m = 0; m < 2; m++) begin addr[k][m] = 5'd0; wdata[k][m] = 32'd0; end
`ifdef SRAM_ARB_LOCK_EN
            lock[k] = 2'b00;
`endif
        end
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt", {gnt1[k], gnt0[k]}, 2'b00);
            chk("rst_rvalid", {rv1[k], rv0[k]}, 2'b00);
            chk("rst_rd_data", rd_data[k], 32'd0);
            chk("rst_pins", {csb_n[k], we_n[k], s_addr[k], s_din[k]}, {1'b1, 1'b1, 5'd0, 32'd0});
            req[k] = 2'b00;
        end
        @(posedge clk); #1 rst = 1'b0;

        issue(0, 0, 1'b1, 5'd3, 32'hDEADBEEF);
        issue(0, 1, 1'b0, 5'd3, 32'hDEADBEEF);
        drain();

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        we[0] = 2'b11;
        addr[0][0] = 5'd10; wdata[0][0] = 32'hA5A5_0010;
        addr[0][1] = 5'd11; wdata[0][1] = 32'h5A5A_0011;
        for (int i = 0; i < 6; i++) begin
            gq.push_back('{0, i % 2});
            aq.push_back('{0, 1'b0, (i % 2) ? 5'd11 : 5'd10, (i % 2) ? 32'h5A5A_0011 : 32'hA5A5_0010});
        end
        req[0] = 2'b11;
        begin
            int n = 0, t = 0;
            while (n < 6 && t < 40) begin @(negedge clk); t++; if (gnt0[0] || gnt1[0]) n++; end
            if (n < 6) timeout("tie_grants");
        end
        @(posedge clk); #1 req[0] = 2'b00;
        issue(0, 1, 1'b0, 5'd10, 32'hA5A5_0010);
        issue(0, 0, 1'b0, 5'd11, 32'h5A5A_0011);
        drain();

        issue(1, 1, 1'b1, 5'd31, 32'h0000_00FF);
        issue(1, 0, 1'b0, 5'd31, 32'h0000_00FF);
        drain();

        issue(2, 1, 1'b1, 5'd5, 32'h1234_5678);
        issue(2, 0, 1'b0, 5'd5, 32'h1234_5678);
        drain();
        @(posedge clk); #1;
        req[2][0] = 1'b1; we[2][0] = 1'b0; addr[2][0] = 5'd5;
        gq.push_back('{2, 0});
        aq.push_back('{2, 1'b1, 5'd5, 32'd0});
        wait_gnt(2, 0);
        req[2][0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_mid_csb", {31'd0, csb_n[2]}, 32'd1);
        chk("rst_mid_rvalid", {rv1[2], rv0[2]}, 2'b00);
        chk("rst_mid_rd_data", rd_data[2], 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        we[2] = 2'b11;
        addr[2][0] = 5'd7; wdata[2][0] = 32'hC0C0_0007;
        addr[2][1] = 5'd8; wdata[2][1] = 32'hD0D0_0008;
        gq.push_back('{2, 0});
        aq.push_back('{2, 1'b0, 5'd7, 32'hC0C0_0007});
        req[2] = 2'b11;
        wait_gnt(2, 0);
        req[2] = 2'b00;
        drain();

`ifdef SRAM_ARB_LOCK_EN
        lock[0][0] = 1'b1;
        issue(0, 0, 1'b0, 5'd10, 32'hA5A5_0010);
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 5'd12; wdata[0][1] = 32'hEEEE_0012;
        issue(0, 0, 1'b0, 5'd11, 32'h5A5A_0011);
        issue(0, 0, 1'b0, 5'd10, 32'hA5A5_0010);
        lock[0][0] = 1'b0;
        issue(0, 0, 1'b0, 5'd11, 32'h5A5A_0011);
        gq.push_back('{0, 1});
        aq.push_back('{0, 1'b0, 5'd12, 32'hEEEE_0012});
        wait_gnt(0, 1);
        req[0][1] = 1'b0;
        drain();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-master arbiter and sequencer for the single-port 32×32 SRAM macro. It shares the macro between master 0 (the UART command controller) and master 1 (a background requester such as a BIST or scrub engine), using round-robin arbitration. It owns every SRAM pin and issues exactly one access per grant. Read data is returned to the requesting master after a fixed latency.

## Interface
Parameters:
- ADDR_W, 5, SRAM word address width.
- DATA_W, 32, SRAM word width.
- RD_LAT, 1, cycles from the SRAM access cycle to valid `sram_dout`. Legal values are 1–3.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- m0_req / m1_req  in  1  access request; held high with command fields stable until the matching gnt.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  word address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  one-cycle accept pulse; the command is latched on this edge.
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse; `rd_data` is valid for that master.
- rd_data  out  DATA_W  registered read data, shared by both masters.
- sram_csb_n  out  1  chip select, active-low.
- sram_we_n  out  1  0 = write, 1 = read.
- sram_addr  out  ADDR_W  SRAM address.
- sram_din  out  DATA_W  SRAM write data.
- sram_dout  in  DATA_W  SRAM read data.

## Operation
- States: IDLE, ACCESS, RDWAIT.
- IDLE: a grant is issued combinationally in the same cycle as req.
  - If only one req is high, that master is granted.
  - If both are high, the master other than `last_q` is granted.
  - On the grant edge: command registered, `last_q` ← granted master, state → ACCESS.
- ACCESS (always exactly one cycle):
  - Drives `sram_csb_n`=0, `sram_we_n`=!we, `sram_addr`, and `sram_din` (write data on a write, 0 on a read).
  - Write → IDLE. Read → RDWAIT with counter loaded to RD_LAT−1.
- RDWAIT:
  - Counter decrements each cycle.
  - When the counter reaches 0: `rd_data` ← `sram_dout`, the owner's rvalid is set for the next cycle, state → IDLE.
- `sram_csb_n`=1 in every state except ACCESS. `sram_we_n`=1, `sram_addr`=0 and `sram_din`=0 whenever deselected.
- No gnt is asserted outside IDLE; a req raised in ACCESS or RDWAIT waits.
- `rd_data` holds its value until the next read completes.
- Reset values:
  - state IDLE; `last_q`=1, so master 0 wins the first tie.
  - gnt outputs 0, rvalid outputs 0, `rd_data`=0.
  - `sram_csb_n`=1, `sram_we_n`=1, `sram_addr`=0, `sram_din`=0.
- Reset mid-operation: SRAM outputs deselect immediately (asynchronously); any in-flight read is discarded and no rvalid is produced.
- A write followed by a read of the same address, from either master, returns the new data (accesses are strictly serialised).

## Timing
- Grant at T0 → ACCESS at T1.
- Write: IDLE again at T2; the next gnt is possible at T2.
- Read: `sram_dout` sampled at the end of cycle T1+RD_LAT; rvalid high and `rd_data` valid in T2+RD_LAT. Gnt-to-rvalid latency is 2+RD_LAT.
- The rvalid cycle is an IDLE cycle, so a new gnt may coincide with it.
- Throughput: one write per 2 cycles; one read per 2+RD_LAT cycles.
- Continuous requests from both masters alternate strictly: 0,1,0,1…

## Configuration
- SRAM_ARB_LOCK_EN defined:
  - Adds inputs `m0_lock` / `m1_lock` (1 bit, sampled with req).
  - A grant taken with lock=1 makes that master the exclusive owner. While the lock holds, the other master's req is ignored in IDLE and `last_q` is not updated.
  - The lock releases on the owner's next grant taken with lock=0. That access completes, then round-robin resumes.
  - Reset clears the lock.
- Undefined: no lock ports; pure round-robin.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to addr 3 → `m0_gnt` at T0. At T1: `sram_csb_n`=0, `sram_we_n`=0, `sram_addr`=3, `sram_din`=0xDEADBEEF. At T2 `sram_csb_n`=1.
- m1 reads addr 3 after that write, RD_LAT=1 → `m1_rvalid` is a single pulse 3 cycles after `m1_gnt`, `rd_data`=0xDEADBEEF, `m0_rvalid` stays 0.
- Both reqs held high for 6 grants, first tie after reset → grant order 0,1,0,1,0,1; never two gnts in the same cycle.
- Assert rst during RDWAIT of a read with RD_LAT=3 → `sram_csb_n`=1 immediately, no rvalid, `rd_data`=0, next tie goes to m0.
- RD_LAT=2, m0 reads addr 31 holding 0x0000_00FF → gnt-to-rvalid is 4 cycles and `rd_data`=0x000000FF.
- With SRAM_ARB_LOCK_EN: m0 does 3 locked reads, then an unlocked read, while m1_req is held → m1 is granted only after m0's fourth access.
